// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
// Contents:
//   XLEN, REG_AW, NREGS : datapath width, register address width, register count
//   wb_sel_e            : which source owns the write port this cycle
//   lq_entry_t          : one load-queue entry (destination register + data)
package rf_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_sel_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } lq_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding load results until they win the register-file
// write port.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_push, i_wdata     : enqueue an entry (ignored while full)
//   i_pop               : dequeue the head entry (ignored while empty)
//   o_rdata             : head entry, valid whenever o_empty is low
//   o_full, o_empty     : occupancy flags
//   o_count             : number of stored entries, 0..DEPTH
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  lq_entry_t i_wdata,
    input  logic      i_pop,
    output lq_entry_t o_rdata,
    output logic      o_full,
    output logic      o_empty,
    output logic [AW:0] o_count
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the low bits match.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    lq_entry_t   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == DEPTH_C);
    assign o_empty   = (o_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful, and leaving the array out of reset lets it map
    // to plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller for the single write port of the 32x32 register file.
// Merges single-cycle ALU results with queued load results into one
// registered write per cycle and tracks registers awaiting a load result.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   alu_vld, alu_rd, alu_data        : ALU result; alu_stall asks producer to hold
//   lsu_vld, lsu_rd, lsu_data        : load result; lsu_rdy means queue can accept
//   iss_vld, iss_rd                  : load issue, marks iss_rd busy
//   busy                             : per-register pending-load flags (bit 0 = 0)
//   we, dst_addr, dst                : registered register-file write port
module rf_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_vld,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_stall,
    input  logic              lsu_vld,
    output logic              lsu_rdy,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              iss_vld,
    input  logic [REG_AW-1:0] iss_rd,
    output logic [NREGS-1:0]  busy,
    output logic              we,
    output logic [REG_AW-1:0] dst_addr,
    output logic [XLEN-1:0]   dst
);

    localparam int QAW = $clog2(LQ_DEPTH);
    localparam logic [QAW:0] DEPTH_C = (QAW + 1)'(LQ_DEPTH);

    logic              w_full;
    logic              w_empty;
    logic [QAW:0]      w_count;
    logic              w_push;
    logic              w_pop;
    lq_entry_t         w_head;
    lq_entry_t         w_lq_in;
    wb_sel_e           w_sel;
    logic [NREGS-1:0]  w_busy_nxt;

    logic              r_we;
    logic [REG_AW-1:0] r_dst_addr;
    logic [XLEN-1:0]   r_dst;
    logic [NREGS-1:0]  r_busy;

    // Readiness looks at registered occupancy only, so a pop in the same
    // cycle never opens a slot for the incoming load.
    assign lsu_rdy   = (w_count < DEPTH_C);
    assign alu_stall = alu_vld && w_full;

    // Loads to x0 complete the handshake but are never stored.
    assign w_push       = lsu_vld && lsu_rdy && (lsu_rd != '0);
    assign w_lq_in.rd   = lsu_rd;
    assign w_lq_in.data = lsu_data;

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_lq_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A full queue takes priority so the ALU cannot starve loads forever;
    // otherwise the ALU wins because its producer cannot buffer.
    // NOTE: every signal driven from always_comb gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        w_sel = WB_NONE;
        if (w_full)        w_sel = WB_LSU;
        else if (alu_vld)  w_sel = WB_ALU;
        else if (!w_empty) w_sel = WB_LSU;
    end

    assign w_pop = (w_sel == WB_LSU);

    // Clear on pop first, then set on issue, so a same-cycle set of the
    // same register wins. Bit 0 is forced low.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)                       w_busy_nxt[w_head.rd] = 1'b0;
        if (iss_vld && (iss_rd != '0))   w_busy_nxt[iss_rd]    = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_dst_addr <= '0;
            r_dst      <= '0;
            r_busy     <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            unique case (w_sel)
                WB_ALU: begin
                    // An x0 result is consumed without a write; the address
                    // and data registers keep their previous contents.
                    r_we <= (alu_rd != '0);
                    if (alu_rd != '0) begin
                        r_dst_addr <= alu_rd;
                        r_dst      <= alu_data;
                    end
                end
                WB_LSU: begin
                    r_we       <= 1'b1;
                    r_dst_addr <= w_head.rd;
                    r_dst      <= w_head.data;
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    assign we       = r_we;
    assign dst_addr = r_dst_addr;
    assign dst      = r_dst;
    assign busy     = r_busy;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed self-checking bench for rf_wb_ctrl with LQ_DEPTH = 4.
module tb_rf_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_vld;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_vld;
    logic        lsu_rdy;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_vld;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        we;
    logic [4:0]  dst_addr;
    logic [31:0] dst;

    int checks = 0;
    int errors = 0;

    rf_wb_ctrl #(
        .LQ_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_vld   (alu_vld),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .lsu_vld   (lsu_vld),
        .lsu_rdy   (lsu_rdy),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_vld   (iss_vld),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .we        (we),
        .dst_addr  (dst_addr),
        .dst       (dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected write order for the ALU-vs-queue contention phase.
    logic [4:0]  exp_addr [11] = '{20, 21, 22, 23, 10, 24, 11, 25, 12, 13, 14};
    logic [31:0] exp_data [11] = '{32'hB00, 32'hB01, 32'hB02, 32'hB03, 32'hA0, 32'hB04,
                                   32'hA1, 32'hB05, 32'hA2, 32'hA3, 32'hA4};
    logic        exp_rdy   [8] = '{1, 1, 1, 1, 0, 1, 0, 1};
    logic        exp_stall [8] = '{0, 0, 0, 0, 1, 0, 1, 0};

    initial begin
        int ai, li, wi;
        logic acc_alu, acc_lsu;

        rst_n = 1'b0; alu_vld = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_vld = 1'b0; lsu_rd = '0; lsu_data = '0; iss_vld = 1'b0; iss_rd = '0;

        // Reset values
        #12;
        check("rst_we",    32'(we),        32'd0);
        check("rst_addr",  32'(dst_addr),  32'd0);
        check("rst_dst",   dst,            32'd0);
        check("rst_busy",  busy,           32'd0);
        check("rst_rdy",   32'(lsu_rdy),   32'd1);
        check("rst_stall", 32'(alu_stall), 32'd0);
        rst_n = 1'b1;
        step();

        // ALU result written one cycle later
        alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        check("alu_stall0", 32'(alu_stall), 32'd0);
        step();
        alu_vld = 1'b0;
        check("alu_we",   32'(we),       32'd1);
        check("alu_addr", 32'(dst_addr), 32'd5);
        check("alu_dst",  dst,           32'hDEADBEEF);
        step();
        check("idle_we",  32'(we), 32'd0);
        check("idle_dst", dst,     32'hDEADBEEF);

        // Issue load to x7, then its result: busy set, write two cycles later
        iss_vld = 1'b1; iss_rd = 5'd7;
        step();
        iss_vld = 1'b0;
        check("busy7_set", busy, 32'h0000_0080);
        lsu_vld = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
        check("ld_rdy", 32'(lsu_rdy), 32'd1);
        step();
        lsu_vld = 1'b0;
        check("ld_no_bypass", 32'(we), 32'd0);
        check("busy7_hold",   busy,    32'h0000_0080);
        step();
        check("ld_we",       32'(we),       32'd1);
        check("ld_addr",     32'(dst_addr), 32'd7);
        check("ld_dst",      dst,           32'h1234);
        check("busy7_clear", busy,          32'd0);
        step();
        check("ld_we_off", 32'(we), 32'd0);

        // ALU every cycle while 5 loads are offered
        ai = 0; li = 0; wi = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            alu_vld  = (ai < 6);
            alu_rd   = 5'(20 + ai);
            alu_data = 32'hB00 + 32'(ai);
            lsu_vld  = (li < 5);
            lsu_rd   = 5'(10 + li);
            lsu_data = 32'hA0 + 32'(li);
            if (cyc < 8) begin
                check($sformatf("ct_rdy_c%0d", cyc),   32'(lsu_rdy),   32'(exp_rdy[cyc]));
                check($sformatf("ct_stall_c%0d", cyc), 32'(alu_stall), 32'(exp_stall[cyc]));
            end
            acc_alu = alu_vld && !alu_stall;
            acc_lsu = lsu_vld && lsu_rdy;
            step();
            if (acc_alu) ai++;
            if (acc_lsu) li++;
            if (we) begin
                if (wi < 11) begin
                    check($sformatf("ct_addr_w%0d", wi), 32'(dst_addr), 32'(exp_addr[wi]));
                    check($sformatf("ct_dst_w%0d", wi),  dst,           exp_data[wi]);
                end
                wi++;
            end
        end
        alu_vld = 1'b0; lsu_vld = 1'b0;
        check("ct_nwrites",  32'(wi), 32'd11);
        check("ct_alu_acc",  32'(ai), 32'd6);
        check("ct_lsu_acc",  32'(li), 32'd5);
        check("ct_busy",     busy,    32'd0);

        // Writes to x0
        alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step();
        alu_vld = 1'b0;
        check("x0_alu_we",  32'(we), 32'd0);
        check("x0_alu_dst", dst,     32'hA4);
        lsu_vld = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h66;
        step();
        lsu_vld = 1'b0;
        check("x0_ld_we1", 32'(we), 32'd0);
        iss_vld = 1'b1; iss_rd = 5'd0;
        step();
        iss_vld = 1'b0;
        check("x0_ld_we2", 32'(we),      32'd0);
        check("x0_busy",   busy,         32'd0);
        check("x0_rdy",    32'(lsu_rdy), 32'd1);
        step();
        check("x0_ld_we3", 32'(we), 32'd0);

        // Pop of x9 coinciding with a new issue of x9: set wins
        iss_vld = 1'b1; iss_rd = 5'd9;
        step();
        iss_vld = 1'b0;
        check("b9_set", busy, 32'h0000_0200);
        lsu_vld = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        lsu_vld = 1'b0;
        iss_vld = 1'b1; iss_rd = 5'd9;
        step();
        iss_vld = 1'b0;
        check("b9_we",   32'(we),       32'd1);
        check("b9_addr", 32'(dst_addr), 32'd9);
        check("b9_busy", busy,          32'h0000_0200);
        step();
        check("b9_busy_hold", busy, 32'h0000_0200);

        // Async reset with 3 queued loads and busy bits set
        iss_vld = 1'b1; iss_rd = 5'd3;
        step();
        iss_rd = 5'd4;
        step();
        iss_vld = 1'b0;
        alu_vld = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        for (int k = 0; k < 3; k++) begin
            lsu_vld = 1'b1; lsu_rd = 5'(3 + k); lsu_data = 32'h30 + 32'(k);
            step();
        end
        lsu_vld = 1'b0;
        check("pre_rst_busy", busy,    32'h0000_0218);
        check("pre_rst_we",   32'(we), 32'd1);
        check("pre_rst_dst",  dst,     32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we",    32'(we),        32'd0);
        check("arst_addr",  32'(dst_addr),  32'd0);
        check("arst_dst",   dst,            32'd0);
        check("arst_busy",  busy,           32'd0);
        check("arst_rdy",   32'(lsu_rdy),   32'd1);
        check("arst_stall", 32'(alu_stall), 32'd0);
        alu_vld = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("post_rst_we_%0d", k), 32'(we), 32'd0);
        end
        check("post_rst_busy", busy, 32'd0);
        check("post_rst_dst",  dst,  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
